// File: rtl/deal_sequencer_if.sv
// -----------------------------------------------------------------------------
// deal_sequencer_if
//   Links the hand sequencer to the card datapath.
//   Datapath -> sequencer : pcard3 (player third-card rank, 0 = none),
//                           pscore / dscore (hand scores, 0-9)
//   Sequencer -> datapath : six one-hot card load strobes
//   Sequencer -> display  : player / dealer win lights
//   master : the sequencer side
//   slave  : the datapath / observer side
// -----------------------------------------------------------------------------
interface deal_sequencer_if;
    logic [3:0] pcard3;
    logic [3:0] pscore;
    logic [3:0] dscore;
    logic       load_pcard1;
    logic       load_pcard2;
    logic       load_pcard3;
    logic       load_dcard1;
    logic       load_dcard2;
    logic       load_dcard3;
    logic       player_win_light;
    logic       dealer_win_light;

    modport master (
        input  pcard3, pscore, dscore,
        output load_pcard1, load_pcard2, load_pcard3,
        output load_dcard1, load_dcard2, load_dcard3,
        output player_win_light, dealer_win_light
    );

    modport slave (
        output pcard3, pscore, dscore,
        input  load_pcard1, load_pcard2, load_pcard3,
        input  load_dcard1, load_dcard2, load_dcard3,
        input  player_win_light, dealer_win_light
    );
endinterface

// File: rtl/deal_sequencer.sv
// -----------------------------------------------------------------------------
// deal_sequencer
//   Control FSM for one baccarat hand. Deals P1, D1, P2, D2, applies the
//   player and banker third-card rules, then holds the win lights until reset.
//   slow_clock : hand clock, all state changes on its rising edge
//   resetb     : asynchronous active-low reset, returns to S_IDLE
//   bus        : datapath link (scores, pcard3 in; load strobes, lights out)
//   All outputs are Moore-decoded from the state register.
// -----------------------------------------------------------------------------
module deal_sequencer (
    input  logic              slow_clock,
    input  logic              resetb,
    deal_sequencer_if.master  bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_P1, S_D1, S_P2, S_D2, S_EVAL4, S_P3, S_EVAL5, S_D3, S_DONE
    } state_e;

    state_e state_q, state_d;

    // Baccarat value of the player's third card; face cards and the
    // unused codes 14-15 count as zero.
    logic [3:0] p3_val;
    logic       banker_draw;
    logic       natural;

    assign p3_val  = (bus.pcard3 >= 4'd10) ? 4'd0 : bus.pcard3;
    assign natural = (bus.pscore >= 4'd8) || (bus.dscore >= 4'd8);

    // Banker rule after the player has drawn, keyed on the banker's
    // two-card score and the player's third-card value.
    always_comb begin
        banker_draw = 1'b0;
        case (bus.dscore)
            4'd0, 4'd1, 4'd2: banker_draw = 1'b1;
            4'd3:             banker_draw = (p3_val != 4'd8);
            4'd4:             banker_draw = (p3_val >= 4'd2) && (p3_val <= 4'd7);
            4'd5:             banker_draw = (p3_val >= 4'd4) && (p3_val <= 4'd7);
            4'd6:             banker_draw = (p3_val == 4'd6) || (p3_val == 4'd7);
            default:          banker_draw = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_P1;
            S_P1:    state_d = S_D1;
            S_D1:    state_d = S_P2;
            S_P2:    state_d = S_D2;
            S_D2:    state_d = S_EVAL4;
            S_EVAL4: begin
                if (natural)                   state_d = S_DONE;
                else if (bus.pscore <= 4'd5)   state_d = S_P3;
                else if (bus.dscore <= 4'd5)   state_d = S_D3;
                else                           state_d = S_DONE;
            end
            S_P3:    state_d = S_EVAL5;
            S_EVAL5: state_d = banker_draw ? S_D3 : S_DONE;
            S_D3:    state_d = S_DONE;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode
    logic lp1, lp2, lp3, ld1, ld2, ld3, pwin, dwin;

    always_comb begin
        lp1  = 1'b0;
        lp2  = 1'b0;
        lp3  = 1'b0;
        ld1  = 1'b0;
        ld2  = 1'b0;
        ld3  = 1'b0;
        pwin = 1'b0;
        dwin = 1'b0;
        case (state_q)
            S_P1:   lp1 = 1'b1;
            S_D1:   ld1 = 1'b1;
            S_P2:   lp2 = 1'b1;
            S_D2:   ld2 = 1'b1;
            S_P3:   lp3 = 1'b1;
            S_D3:   ld3 = 1'b1;
            // A tie lights both, so each light is a >= compare.
            S_DONE: begin
                pwin = (bus.pscore >= bus.dscore);
                dwin = (bus.dscore >= bus.pscore);
            end
            default: ;
        endcase
    end

    assign bus.load_pcard1      = lp1;
    assign bus.load_pcard2      = lp2;
    assign bus.load_pcard3      = lp3;
    assign bus.load_dcard1      = ld1;
    assign bus.load_dcard2      = ld2;
    assign bus.load_dcard3      = ld3;
    assign bus.player_win_light = pwin;
    assign bus.dealer_win_light = dwin;

endmodule

// File: tb/tb_deal_sequencer.sv
// -----------------------------------------------------------------------------
// tb_deal_sequencer
//   Drives deal_sequencer through a behavioural card datapath and compares
//   the strobes and lights against a hand-level reference of baccarat rules.
// -----------------------------------------------------------------------------
module tb_deal_sequencer;

    logic slow_clock = 1'b0;
    logic resetb     = 1'b0;
    always #5 slow_clock = ~slow_clock;

    deal_sequencer_if dif();

    deal_sequencer dut (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .bus        (dif)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int bv(input logic [3:0] r);
        return (r >= 4'd10) ? 0 : int'(r);
    endfunction

    // Banker draw after a player draw: bitmask of third-card values that
    // make the banker draw, per banker two-card score.
    function automatic bit banker_ref(input int dt, input logic [3:0] rank);
        logic [9:0] m;
        case (dt)
            0, 1, 2: m = 10'b11_1111_1111;
            3:       m = 10'b10_1111_1111;
            4:       m = 10'b00_1111_1100;
            5:       m = 10'b00_1111_0000;
            6:       m = 10'b00_1100_0000;
            default: m = 10'b00_0000_0000;
        endcase
        return m[bv(rank)];
    endfunction

    // Behavioural datapath: latches a deck card on each strobe.
    logic [3:0] dk_p1, dk_p2, dk_p3, dk_d1, dk_d2, dk_d3;
    logic [3:0] pc1, pc2, pc3, dc1, dc2, dc3;

    always @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            pc1 <= '0; pc2 <= '0; pc3 <= '0;
            dc1 <= '0; dc2 <= '0; dc3 <= '0;
        end else begin
            if (dif.load_pcard1) pc1 <= dk_p1;
            if (dif.load_pcard2) pc2 <= dk_p2;
            if (dif.load_pcard3) pc3 <= dk_p3;
            if (dif.load_dcard1) dc1 <= dk_d1;
            if (dif.load_dcard2) dc2 <= dk_d2;
            if (dif.load_dcard3) dc3 <= dk_d3;
        end
    end

    logic [3:0] m_ps, m_ds;
    always_comb begin
        m_ps = 4'((bv(pc1) + bv(pc2) + bv(pc3)) % 10);
        m_ds = 4'((bv(dc1) + bv(dc2) + bv(dc3)) % 10);
    end

    // Override lets the bench hold raw score/rank values on the inputs.
    logic       ovr = 1'b0;
    logic [3:0] ovr_ps = '0, ovr_ds = '0, ovr_pc3 = '0;

    assign dif.pscore = ovr ? ovr_ps  : m_ps;
    assign dif.dscore = ovr ? ovr_ds  : m_ds;
    assign dif.pcard3 = ovr ? ovr_pc3 : pc3;

    wire [5:0] strb = {dif.load_pcard1, dif.load_pcard2, dif.load_pcard3,
                       dif.load_dcard1, dif.load_dcard2, dif.load_dcard3};
    wire [1:0] lights = {dif.player_win_light, dif.dealer_win_light};

    task automatic tick();
        @(posedge slow_clock);
        @(negedge slow_clock);
    endtask

    // Pulse reset while the clock is low; the next rising edge is edge 1.
    task automatic start_hand();
        @(negedge slow_clock);
        resetb = 1'b0;
        #1;
        resetb = 1'b1;
    endtask

    task automatic run_hand(input logic [3:0] p1, p2, p3, d1, d2, d3,
                            input int hold, input string tag);
        int pt, dt, pf, df, done, excl_bad, hold_bad;
        bit pdraw, bdraw;
        logic [1:0] exp_l;
        logic [3:0] cnt [6];
        dk_p1 = p1; dk_p2 = p2; dk_p3 = p3;
        dk_d1 = d1; dk_d2 = d2; dk_d3 = d3;
        ovr = 1'b0;
        pt = (bv(p1) + bv(p2)) % 10;
        dt = (bv(d1) + bv(d2)) % 10;
        pdraw = 0;
        bdraw = 0;
        if (pt >= 8 || dt >= 8) begin
            done = 6;
        end else if (pt <= 5) begin
            pdraw = 1;
            bdraw = banker_ref(dt, p3);
            done  = bdraw ? 9 : 8;
        end else begin
            bdraw = (dt <= 5);
            done  = bdraw ? 7 : 6;
        end
        pf = (pt + (pdraw ? bv(p3) : 0)) % 10;
        df = (dt + (bdraw ? bv(d3) : 0)) % 10;
        exp_l = {pf >= df, df >= pf};
        for (int i = 0; i < 6; i++) cnt[i] = '0;
        excl_bad = 0;
        hold_bad = 0;
        start_hand();
        for (int k = 1; k <= done + hold; k++) begin
            tick();
            if ($countones(strb) > 1) excl_bad++;
            for (int i = 0; i < 6; i++) if (strb[i]) cnt[i] = cnt[i] + 4'd1;
            if (k == done - 1) chk({tag, "_lights_pre"}, 32'(lights), 32'd0);
            if (k == done)     chk({tag, "_lights"}, 32'(lights), 32'(exp_l));
            if (k > done && (lights !== exp_l || strb !== 6'd0)) hold_bad++;
        end
        chk({tag, "_exclusive"}, 32'(excl_bad), 32'd0);
        chk({tag, "_fires"}, {8'd0, cnt[5], cnt[4], cnt[3], cnt[2], cnt[1], cnt[0]},
            {8'd0, 4'd1, 4'd1, 4'(pdraw), 4'd1, 4'd1, 4'(bdraw)});
        chk({tag, "_hold"}, 32'(hold_bad), 32'd0);
    endtask

    initial begin
        dk_p1 = 4'd1; dk_p2 = 4'd2; dk_p3 = 4'd3;
        dk_d1 = 4'd4; dk_d2 = 4'd5; dk_d3 = 4'd6;
        #12;
        chk("reset_outs", 32'({strb, lights}), 32'd0);

        // Mid-hand reset from S_P2.
        @(negedge slow_clock);
        resetb = 1'b1;
        tick();
        chk("edge1_p1", 32'(strb), 32'b10_0000);
        tick();
        tick();
        chk("in_p2", 32'(strb), 32'b01_0000);
        #2 resetb = 1'b0;
        #1 chk("abort_outs", 32'({strb, lights}), 32'd0);
        #1 resetb = 1'b1;
        tick();
        chk("restart_p1", 32'(strb), 32'b10_0000);

        run_hand(4'd3, 4'd5, 4'd9, 4'd2, 4'd3, 4'd4, 2,  "natural");
        run_hand(4'd1, 4'd5, 4'd9, 4'd2, 4'd2, 4'd5, 2,  "stand_bdraw");
        run_hand(4'd3, 4'd4, 4'd9, 4'd3, 4'd4, 4'd1, 20, "tie");

        // Banker rule sweep with the player's score held at 3.
        ovr = 1'b1;
        for (int d = 0; d < 8; d++) begin
            for (int r = 0; r < 16; r++) begin
                ovr_ps  = 4'd3;
                ovr_ds  = 4'(d);
                ovr_pc3 = 4'(r);
                start_hand();
                repeat (8) tick();
                chk($sformatf("banker_d%0d_r%0d", d, r), 32'(strb[0]),
                    32'(banker_ref(d, 4'(r))));
            end
        end

        // Out-of-range scores still compare as plain unsigned values.
        ovr_ps = 4'd12; ovr_ds = 4'd10; ovr_pc3 = 4'd0;
        start_hand();
        repeat (6) tick();
        chk("oor_lights", 32'({strb, lights}), 32'b0000_0010);
        ovr = 1'b0;

        for (int h = 0; h < 40; h++) begin
            run_hand(4'($urandom_range(1, 13)), 4'($urandom_range(1, 13)),
                     4'($urandom_range(1, 13)), 4'($urandom_range(1, 13)),
                     4'($urandom_range(1, 13)), 4'($urandom_range(1, 13)),
                     1, $sformatf("rand%0d", h));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/deal_sequencer.md
# deal_sequencer

Control state machine for one baccarat hand. Sits opposite the card datapath: it consumes the datapath's `pcard3_out`, `pscore_out` and `dscore_out` and produces the six one-hot card-load strobes. It deals four cards in fixed order, applies the player and banker third-card rules, and then drives the win lights until reset. Everything runs on the slow (manual-step) clock. Each active load strobe is latched by the datapath on the same clock edge on which this block advances state.

## Interface

Parameters: none.

- `slow_clock` in 1: hand clock. All state changes occur on its rising edge.
- `resetb` in 1: asynchronous, active-low reset.
- `pcard3` in 4: player third-card rank (0 = no card, 1–13 = A..K), taken from the datapath's `pcard3_out`.
- `pscore` in 4: player hand score, 0–9.
- `dscore` in 4: dealer hand score, 0–9.
- `load_pcard1`, `load_pcard2`, `load_pcard3` out 1 each: player card load strobes.
- `load_dcard1`, `load_dcard2`, `load_dcard3` out 1 each: dealer card load strobes.
- `player_win_light` out 1: player won, or the hand is a tie.
- `dealer_win_light` out 1: dealer won, or the hand is a tie.

## Operation

All outputs are Moore outputs, decoded from state only. At most one load strobe is high in any state.

States, with the strobe each asserts:
- S_IDLE: none.
- S_P1: `load_pcard1`.
- S_D1: `load_dcard1`.
- S_P2: `load_pcard2`.
- S_D2: `load_dcard2`.
- S_EVAL4: none.
- S_P3: `load_pcard3`.
- S_EVAL5: none.
- S_D3: `load_dcard3`.
- S_DONE: win lights only.

Transitions:
- S_IDLE→S_P1→S_D1→S_P2→S_D2→S_EVAL4, unconditionally.
- S_EVAL4, natural (`pscore`≥8 or `dscore`≥8) → S_DONE.
- S_EVAL4, else if `pscore`≤5 → S_P3.
- S_EVAL4, else (`pscore` is 6 or 7) → S_D3 if `dscore`≤5, otherwise S_DONE.
- S_P3 → S_EVAL5.
- S_EVAL5: compute v = (`pcard3`≥10) ? 0 : `pcard3`. The banker draws (→S_D3, otherwise →S_DONE) when any of these holds:
  - `dscore`≤2;
  - `dscore`=3 and v≠8;
  - `dscore`=4 and 2≤v≤7;
  - `dscore`=5 and 4≤v≤7;
  - `dscore`=6 and v∈{6,7}.
  - `dscore`=7 never draws.
- S_D3 → S_DONE.
- S_DONE is absorbing. Only `resetb` leaves it.

Result in S_DONE, compared as unsigned 4-bit values:
- `pscore`>`dscore`: player light only.
- `dscore`>`pscore`: dealer light only.
- Equal: both lights.
- Both lights are 0 in every other state.

Input range:
- Score inputs above 9 are out of contract, but must still decode deterministically through the same comparisons.
- `pcard3` values 14–15 are treated as v=0.

## Timing

- Reset: while `resetb`=0, state is forced to S_IDLE asynchronously. Every output is 0 during and immediately after reset.
- Reset asserted mid-hand aborts the hand. Any strobe drops in the same instant, with no clock required.
- Edge 1 after release: S_IDLE→S_P1.
- Edge k, for k=2..5: the card for the strobe high before edge k is latched by the datapath, and state advances.
- Edge 5 moves S_D2→S_EVAL4. `pscore`/`dscore` are settled by then and are sampled at edge 6.
- Edge 6: decision from S_EVAL4.
- Path lengths from release:
  - Natural: S_DONE after 6 edges.
  - Player stands, banker draws: S_D3 at 6, S_DONE at 7.
  - Player draws: S_P3 at 6, S_EVAL5 at 7, then S_D3 or S_DONE at 8; a banker draw reaches S_DONE at 9.
- In S_EVAL5, `pcard3` already reflects the card loaded at edge 7.
- Win lights become valid in the first cycle of S_DONE. They track the inputs combinationally for as long as the block stays in S_DONE.

## Test plan

A behavioural datapath model supplies the score inputs.

- Reset mid-hand: pulse `resetb` low in S_P2 → all outputs 0 at once; edge 1 after release asserts `load_pcard1` only.
- Natural: the model returns `pscore`=8, `dscore`=5 at S_EVAL4 → no third-card strobe ever; edge 6 enters S_DONE with `player_win_light`=1, `dealer_win_light`=0.
- Player stands, banker draws: `pscore`=6, `dscore`=4; after D3 the model returns `dscore`=9 → `load_dcard3` high for exactly one cycle; dealer light only at edge 7.
- Banker rule table: `pscore`=3, sweep `dscore`=0..7 × `pcard3`=0..13 → `load_dcard3` follows the rule set exactly. Spot checks: (3, rank 8) no draw; (6, rank 7) draw; (4, rank 12) no draw.
- Tie: the model ends with `pscore`=`dscore`=7 → both lights 1 and held for 20 more edges; no strobe reasserts.
- Strobe exclusivity: across all random legal hands, at most one load strobe is high per cycle and each fires at most once per hand.
